// File: rtl/dm_responder_if.sv
// Bus bundle for dm_responder: the core data-memory port plus the loader
// valid/ready port. The slave side is the memory; the master side is core/loader.
interface dm_responder_if #(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32
);
   logic              DM_enable;
   logic              DM_read;
   logic              DM_write;
   logic [ADDR_W-1:0] DM_address;
   logic [DATA_W-1:0] DM_in;
   logic [DATA_W-1:0] DM_out;

   logic              ld_valid;
   logic              ld_ready;
   logic              ld_write;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_wdata;
   logic [DATA_W-1:0] ld_rdata;
   logic              ld_rvalid;

   modport master (
      output DM_enable, DM_read, DM_write, DM_address, DM_in,
      input  DM_out,
      output ld_valid, ld_write, ld_addr, ld_wdata,
      input  ld_ready, ld_rdata, ld_rvalid
   );

   modport slave (
      input  DM_enable, DM_read, DM_write, DM_address, DM_in,
      output DM_out,
      input  ld_valid, ld_write, ld_addr, ld_wdata,
      output ld_ready, ld_rdata, ld_rvalid
   );
endinterface

// File: rtl/dm_responder.sv
// Word-addressed single-port data memory with registered 1-cycle core reads,
// a lower-priority loader port and an optional post-reset clear walk.
module dm_responder #(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 32,
   parameter bit CLEAR_ON_RESET = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   dm_responder_if.slave    bus,
   output logic             busy,
   output logic             conflict
);

   localparam int DEPTH = 2 ** ADDR_W;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] clr_cnt;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              core_req;
   logic              core_wr;
   logic              core_rd;
   logic              ld_hs;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   assign bus.ld_ready = (state == IDLE) && !core_req;
   assign busy         = (state == CLEAR);

   always_comb begin
      core_req = bus.DM_enable && (bus.DM_read || bus.DM_write);
      core_wr  = core_req && bus.DM_write && (state == IDLE);
      core_rd  = core_req && bus.DM_read && !bus.DM_write && (state == IDLE);
      ld_hs    = bus.ld_valid && bus.ld_ready;

      // One write port: clear walk, then core, then loader. Nothing writes in reset.
      wr_en   = 1'b0;
      wr_addr = bus.DM_address;
      wr_data = bus.DM_in;
      if (rst) begin
         if (state == CLEAR) begin
            wr_en   = 1'b1;
            wr_addr = clr_cnt;
            wr_data = '0;
         end else if (core_wr) begin
            wr_en   = 1'b1;
         end else if (ld_hs && bus.ld_write) begin
            wr_en   = 1'b1;
            wr_addr = bus.ld_addr;
            wr_data = bus.ld_wdata;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
         clr_cnt      <= '0;
         bus.DM_out   <= '0;
         bus.ld_rdata <= '0;
         bus.ld_rvalid <= 1'b0;
         conflict     <= 1'b0;
      end else begin
         bus.ld_rvalid <= 1'b0;
         case (state)
            CLEAR: begin
               clr_cnt <= clr_cnt + 1'b1;
               if (clr_cnt == {ADDR_W{1'b1}}) begin
                  state <= IDLE;
               end
            end
            default: begin
               if (core_rd) begin
                  bus.DM_out <= mem[bus.DM_address];
               end
               if (ld_hs && !bus.ld_write) begin
                  bus.ld_rdata  <= mem[bus.ld_addr];
                  bus.ld_rvalid <= 1'b1;
               end
            end
         endcase
         // Sticky: core access dropped during clear, or read+write collided.
         if (core_req && ((state == CLEAR) || (bus.DM_read && bus.DM_write))) begin
            conflict <= 1'b1;
         end
      end
   end

endmodule
